// File: rtl/cook_timer.sv
// Microwave cook timer: reset-dominant registered SR latch for the magnetron
// enable plus a 4-digit BCD MM:SS countdown ticked once per CLK_HZ cycles.
module cook_timer #(
  parameter int CLK_HZ  = 100,
  parameter int PRESC_W = 7
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        S,
  input  logic        R,
  input  logic        clearn,
  input  logic        load,
  input  logic [15:0] load_bcd,
  output logic        magnetron_on,
  output logic        timer_done,
  output logic [15:0] time_bcd,
  output logic        zero
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  logic               mag_q,   mag_d;
  logic               done_q,  done_d;
  logic [15:0]        time_q,  time_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  function automatic logic [3:0] sat_digit(input logic [3:0] d,
                                           input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Loaded times are clamped to a legal MM:SS value, so the borrow chain
  // below never sees a non-BCD digit.
  function automatic logic [15:0] sat_bcd(input logic [15:0] v);
    return {sat_digit(v[15:12], 4'd9), sat_digit(v[11:8], 4'd9),
            sat_digit(v[7:4],   4'd5), sat_digit(v[3:0],  4'd9)};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    logic       borrow;
    mt = t[15:12];
    mo = t[11:8];
    st = t[7:4];
    so = t[3:0];
    borrow = (so == 4'd0);
    so     = borrow ? 4'd9 : so - 4'd1;
    if (borrow) begin
      borrow = (st == 4'd0);
      st     = borrow ? 4'd5 : st - 4'd1;
    end
    if (borrow) begin
      borrow = (mo == 4'd0);
      mo     = borrow ? 4'd9 : mo - 4'd1;
    end
    if (borrow) mt = mt - 4'd1;
    return {mt, mo, st, so};
  endfunction

  assign zero = (time_q == 16'h0000);

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the priority chain can leave one unassigned and infer a latch.
  always_comb begin
    mag_d   = mag_q;
    done_d  = done_q;
    time_d  = time_q;
    presc_d = presc_q;
    if (!clearn) begin
      mag_d   = 1'b0;
      done_d  = 1'b0;
      time_d  = 16'h0000;
      presc_d = '0;
    end else if (R) begin
      // Pause: time and prescaler hold, any coinciding tick is dropped.
      mag_d = 1'b0;
    end else if (load && !mag_q) begin
      time_d  = sat_bcd(load_bcd);
      presc_d = '0;
      done_d  = 1'b0;
    end else if (S && !mag_q) begin
      if (!zero) mag_d = 1'b1;
    end else if (mag_q) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        time_d  = bcd_dec(time_q);
        if (time_q == 16'h0001) begin
          mag_d  = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
      time_q  <= 16'h0000;
      presc_q <= '0;
    end else begin
      mag_q   <= mag_d;
      done_q  <= done_d;
      time_q  <= time_d;
      presc_q <= presc_d;
    end
  end

  assign magnetron_on = mag_q;
  assign timer_done   = done_q;
  assign time_bcd     = time_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer at CLK_HZ=4: expectations are queued when the
// stimulus is applied and popped/compared once the DUT has had time to respond.
module tb_cook_timer;

  localparam int CLK_HZ  = 4;
  localparam int PRESC_W = 2;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic        S        = 1'b0;
  logic        R        = 1'b0;
  logic        clearn   = 1'b1;
  logic        load     = 1'b0;
  logic [15:0] load_bcd = 16'h0000;
  logic        magnetron_on;
  logic        timer_done;
  logic [15:0] time_bcd;
  logic        zero;

  cook_timer #(.CLK_HZ(CLK_HZ), .PRESC_W(PRESC_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .S            (S),
    .R            (R),
    .clearn       (clearn),
    .load         (load),
    .load_bcd     (load_bcd),
    .magnetron_on (magnetron_on),
    .timer_done   (timer_done),
    .time_bcd     (time_bcd),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        mag;
    logic        done;
    logic [15:0] t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic mag,
                            input logic done, input logic [15:0] t);
    exp_t e;
    e.tag  = tag;
    e.mag  = mag;
    e.done = done;
    e.t    = t;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".mag"},  {15'd0, magnetron_on}, {15'd0, e.mag});
      check({e.tag, ".done"}, {15'd0, timer_done},   {15'd0, e.done});
      check({e.tag, ".time"}, time_bcd,              e.t);
      check({e.tag, ".zero"}, {15'd0, zero},         {15'd0, (e.t == 16'h0000)});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_bcd = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    S = 1'b1;
    step(1);
    S = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    // Reset state before any clock edge.
    expect_out("reset", 1'b0, 1'b0, 16'h0000);
    #3 score();
    @(negedge clk);
    resetn = 1'b1;
    step(1);

    // Load saturation with magnetron off.
    expect_out("sat", 1'b0, 1'b0, 16'h9959);
    do_load(16'hAB7C);
    score();

    // Full cook of 3 s: ticks at 4, 8, 12 cycles after rise.
    do_load(16'h0003);
    expect_out("start", 1'b1, 1'b0, 16'h0003);
    do_start();
    score();
    expect_out("pre_tick1", 1'b1, 1'b0, 16'h0003);
    step(3); score();
    expect_out("tick1", 1'b1, 1'b0, 16'h0002);
    step(1); score();
    expect_out("tick2", 1'b1, 1'b0, 16'h0001);
    step(4); score();
    expect_out("pre_done", 1'b1, 1'b0, 16'h0001);
    step(3); score();
    expect_out("done", 1'b0, 1'b1, 16'h0000);
    step(1); score();

    // S with zero time: stays off, timer_done stays sticky.
    expect_out("s_at_zero", 1'b0, 1'b1, 16'h0000);
    do_start();
    step(2); score();

    // Borrow chain from 10:00.
    expect_out("load_1000", 1'b0, 1'b0, 16'h1000);
    do_load(16'h1000);
    score();
    do_start();
    expect_out("borrow1", 1'b1, 1'b0, 16'h0959);
    step(CLK_HZ); score();
    expect_out("borrow60", 1'b1, 1'b0, 16'h0900);
    step(59 * CLK_HZ); score();

    // R and S together: R dominates.
    expect_out("r_and_s", 1'b0, 1'b0, 16'h0900);
    R = 1'b1; S = 1'b1;
    step(1);
    R = 1'b0; S = 1'b0;
    score();

    // Pause/resume with an ignored load during cooking.
    do_load(16'h0005);
    do_start();
    expect_out("load_ignored", 1'b1, 1'b0, 16'h0005);
    do_load(16'h0099);
    step(1); score();
    expect_out("paused", 1'b0, 1'b0, 16'h0005);
    R = 1'b1;
    step(1);
    R = 1'b0;
    step(10); score();
    expect_out("resumed", 1'b1, 1'b0, 16'h0005);
    do_start();
    step(1); score();
    expect_out("resume_tick", 1'b1, 1'b0, 16'h0004);
    step(1); score();

    // clearn while cooking at 00:42.
    R = 1'b1; step(1); R = 1'b0;
    do_load(16'h0042);
    do_start();
    step(2);
    expect_out("clearn", 1'b0, 1'b0, 16'h0000);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    score();

    // Asynchronous reset mid-count at 01:30.
    do_load(16'h0130);
    do_start();
    step(2);
    expect_out("async_reset", 1'b0, 1'b0, 16'h0000);
    #2 resetn = 1'b0;
    #1 score();
    expect_out("reset_hold", 1'b0, 1'b0, 16'h0000);
    step(6); score();
    resetn = 1'b1;
    expect_out("after_reset", 1'b0, 1'b0, 16'h0000);
    step(6); score();

    if (sb.size() != 0) check("scoreboard_leftover", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
Downstream end of the microwave start/stop set/reset interface. It consumes the S (set) and R (reset) commands and keeps the magnetron enable as a registered, reset-dominant SR latch. It also holds the cook time as a 4-digit BCD MM:SS countdown, decremented once per second while cooking. It produces timer_done, which returns to the start/stop control logic and closes the loop.

Parameters:
CLK_HZ, 100, clock cycles per one-second tick (minimum 2)
PRESC_W, 7, prescaler width; must satisfy 2**PRESC_W >= CLK_HZ

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
S  input  1  set request from start/stop control (level)
R  input  1  reset request from start/stop control (level, dominant)
clearn  input  1  synchronous active-low clear of cook time
load  input  1  single-cycle pulse; capture load_bcd as new cook time
load_bcd  input  16  {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each
magnetron_on  output  1  registered magnetron enable
timer_done  output  1  sticky; countdown reached 00:00
time_bcd  output  16  current remaining time, same packing as load_bcd
zero  output  1  combinational: time_bcd == 0

Behaviour:
- Reset (resetn=0, asynchronous):
  - magnetron_on=0, timer_done=0, time_bcd=0, prescaler=0.
  - All outputs are valid immediately on reset assertion.
- Priority per rising edge, highest first: clearn=0, then R=1, then load, then S, then tick.
- clearn=0:
  - time_bcd=0, prescaler=0, timer_done=0, magnetron_on=0.
  - Applies in any state and overrides every other input that cycle.
- R=1:
  - magnetron_on=0 at the next edge.
  - time_bcd and prescaler hold (pause).
  - No decrement occurs on that edge, even if a tick coincides.
- load=1 with magnetron_on=0 and R=0:
  - time_bcd takes load_bcd with per-digit saturation: any digit >9 becomes 9; sec_tens >5 becomes 5.
  - prescaler=0, timer_done=0.
  - magnetron_on is unchanged that edge, even if S=1.
- load=1 with magnetron_on=1: ignored, no state change from load.
- S=1 with R=0, clearn=1, no accepted load, magnetron_on=0:
  - If zero=0: magnetron_on=1 at the next edge (latency 1 cycle).
  - If zero=1: ignored; magnetron_on stays 0 and timer_done is unchanged.
- S=1 while magnetron_on=1: no effect.
- Prescaler:
  - Counts only while magnetron_on=1 (and R=0, clearn=1).
  - On reaching CLK_HZ-1 it wraps to 0 and generates an internal tick for that edge.
  - It holds its value when paused, so a resumed cook continues the partial second.
- Tick decrement (BCD borrow chain):
  - sec_ones 0→9 with borrow, else -1.
  - sec_tens 0→5 with borrow, else -1.
  - min_ones 0→9 with borrow, else -1.
  - min_tens is decremented only on borrow.
  - Borrow out of min_tens cannot occur, because zero is checked first.
- Completion:
  - On the tick edge where time_bcd goes from 00:01 to 00:00, magnetron_on=0 and timer_done=1 on the same edge.
  - First tick after start: CLK_HZ cycles after magnetron_on rises.
  - Total cook duration for N seconds: N*CLK_HZ cycles from the magnetron_on rise to its fall (excluding pause time).
- timer_done:
  - Sticky. Clears only on an accepted load or on clearn=0.
  - R and S do not clear it.
- Simultaneous events:
  - R and S both 1: R wins, magnetron_on=0.
  - R and load both 1 while on: stop takes effect; load is ignored because magnetron_on=1 was sampled at that edge.
- Reset mid-cook: immediate return to the all-zero state; no tick is generated afterwards.

Test Plan:
- Reset/idle: deassert resetn mid-count at 01:30 with magnetron_on=1 → magnetron_on=0, time_bcd=0x0000, timer_done=0 immediately.
- Load saturation: load_bcd=0xAB7C with magnetron off → time_bcd=0x9959; timer_done=0.
- Full cook, CLK_HZ=4: load 0x0003, pulse S one cycle → magnetron_on rises next cycle. time_bcd steps 0x0002/0x0001/0x0000 at 4, 8 and 12 cycles after the rise. On the 0x0000 edge magnetron_on=0 and timer_done=1.
- Borrow chain, CLK_HZ=4: load 0x1000, start → after 1 tick time_bcd=0x0959; after 60 ticks time_bcd=0x0900.
- Pause/resume, CLK_HZ=4: load 0x0005, start, assert R for 1 cycle at prescaler=2, wait 10 cycles, assert S → time_bcd unchanged while paused. The next tick arrives 2 counting cycles after resume. The load pulse issued during cooking is ignored.
- Edge cases:
  - S with time 0x0000 → magnetron_on stays 0.
  - R=S=1 → magnetron_on=0.
  - clearn=0 while cooking at 0x0042 → time 0x0000, magnetron_on=0, timer_done=0.
  - After completion, S alone → timer_done stays 1.
